// File: rtl/spi_sram_slave_os.sv
// Oversampled SPI SRAM slave. sclk, cs_n and mosi are synchronised into the
// clk domain and edge-detected, so the whole slave runs on the system clock.
// It serves READ, FAST READ, WRITE, RDMR and WRMR against a synchronous byte
// memory and supports byte, page and sequential addressing modes.
module spi_sram_slave_os #(
  parameter int         ADDR_W     = 16,
  parameter int         ADDR_BYTES = 3,
  parameter int         PAGE_W     = 5,
  parameter logic [1:0] RESET_MODE = 2'b01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        mode,
  output logic              busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_RDMR, S_WRMR, S_IGNORE
  } state_t;

  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDMR  = 8'h05;
  localparam logic [7:0] OP_FAST  = 8'h0B;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);
  localparam logic [1:0]        ADDR_LAST = 2'(ADDR_BYTES - 1);

  state_t            state, state_nx;
  logic [1:0]        sclk_sync, cs_sync, mosi_sync;
  logic              sclk_d, cs_d;
  logic              sclk_s, cs_s, mosi_s;
  logic              rise, fall, cs_fall;
  logic [2:0]        bit_cnt;
  logic [1:0]        addr_cnt;
  logic [6:0]        shift_in;
  logic [7:0]        shift_out;
  logic [7:0]        opcode;
  logic [7:0]        rx_byte;
  logic              byte_done, addr_done;
  logic              load_pending;
  logic [ADDR_W-1:0] ptr, ptr_in, ptr_next;

  // Two-flop synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      // NOTE: cs_n resets to its idle (high) level so releasing reset never looks like a select.
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign rx_byte   = {shift_in, mosi_s};
  assign byte_done = rise && (bit_cnt == 3'd7);
  assign addr_done = byte_done && (addr_cnt == ADDR_LAST);
  assign ptr_in    = {ptr[ADDR_W-2:0], mosi_s};
  assign busy      = (state != S_IDLE);

  // Pointer advance: page mode wraps inside the page, everything else is linear.
  always_comb begin
    ptr_next = ptr + ADDR_W'(1);
    if (mode == MODE_PAGE) begin
      ptr_next = (ptr & ~PAGE_MASK) | ((ptr + ADDR_W'(1)) & PAGE_MASK);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; deselect wins over everything.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    if (cs_s) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (cs_fall) state_nx = S_CMD;
        S_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              OP_READ, OP_FAST, OP_WRITE: state_nx = S_ADDR;
              OP_RDMR:                    state_nx = S_RDMR;
              OP_WRMR:                    state_nx = S_WRMR;
              default:                    state_nx = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          if (addr_done) begin
            if (opcode == OP_WRITE)     state_nx = S_WRITE;
            else if (opcode == OP_FAST) state_nx = S_DUMMY;
            else                        state_nx = S_READ;
          end
        end
        S_DUMMY: if (byte_done) state_nx = S_READ;
        S_READ, S_WRITE: if (byte_done && mode == MODE_BYTE) state_nx = S_IGNORE;
        S_WRMR:  if (byte_done) state_nx = S_IGNORE;
        default: ;
      endcase
    end
  end

  // Datapath: bit collection, memory strobes, read shifter and mode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      mem_addr     <= '0;
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wdata    <= 8'h00;
      mode         <= RESET_MODE;
      bit_cnt      <= 3'd0;
      addr_cnt     <= 2'd0;
      shift_in     <= 7'd0;
      shift_out    <= 8'h00;
      opcode       <= 8'h00;
      ptr          <= '0;
      load_pending <= 1'b0;
    end else begin
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      // Read data arrives one clk after the read strobe.
      load_pending <= mem_en && !mem_wr;
      if (load_pending) shift_out <= mem_rdata;

      if (cs_s) begin
        bit_cnt  <= 3'd0;
        addr_cnt <= 2'd0;
        miso     <= 1'b0;
        miso_oe  <= 1'b0;
      end else begin
        if (rise && state != S_IDLE) begin
          bit_cnt  <= bit_cnt + 3'd1;
          shift_in <= rx_byte[6:0];
        end
        if (fall && (state == S_READ || state == S_RDMR)) begin
          miso      <= shift_out[7];
          miso_oe   <= 1'b1;
          shift_out <= {shift_out[6:0], 1'b0};
        end
        case (state)
          S_CMD: begin
            if (byte_done) begin
              opcode   <= rx_byte;
              addr_cnt <= 2'd0;
              if (rx_byte == OP_RDMR) shift_out <= {mode, 6'b0};
            end
          end
          S_ADDR: begin
            if (rise) ptr <= ptr_in;
            if (byte_done) addr_cnt <= addr_cnt + 2'd1;
            if (addr_done && opcode == OP_READ) begin
              mem_en   <= 1'b1;
              mem_addr <= ptr_in;
            end
          end
          S_DUMMY: begin
            if (byte_done) begin
              mem_en   <= 1'b1;
              mem_addr <= ptr;
            end
          end
          S_READ: begin
            if (byte_done && mode != MODE_BYTE) begin
              ptr      <= ptr_next;
              mem_en   <= 1'b1;
              mem_addr <= ptr_next;
            end
          end
          S_WRITE: begin
            if (byte_done) begin
              mem_en    <= 1'b1;
              mem_wr    <= 1'b1;
              mem_wdata <= rx_byte;
              mem_addr  <= ptr;
              ptr       <= ptr_next;
            end
          end
          S_RDMR: if (byte_done) shift_out <= {mode, 6'b0};
          S_WRMR: if (byte_done) mode <= rx_byte[7:6];
          S_IGNORE: begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
